control_unit: RTL and testbench

Hardwired Moore control sequencer for the MiniSRC DataPath, directly upstream of it. It decodes the IR and steps through the fetch cycles T0–T2 and the execute cycles T3–T6. Each cycle it drives the one-hot datapath strobes and a 4-bit ALU select. It replaces the per-test control FSM that benches currently hand-code; scope is the register-format ALU instructions plus halt.

---
 rtl/minisrc_pkg.sv | 80 ++++++++
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit.sv | 140 ++++++++++++++
 tb/tb_control_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared encodings for the MiniSRC control sequencer: opcodes, ALU selects,
// state encoding and the datapath strobe bundle.
package minisrc_pkg;

    localparam int CU_OPC_W = 5;
    localparam int CU_ALU_W = 4;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_HALT = 5'd28;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_MUL  = 4'h4;
    localparam logic [3:0] ALU_DIV  = 4'h6;
    localparam logic [3:0] ALU_SHR  = 4'h7;
    localparam logic [3:0] ALU_SHRA = 4'h8;
    localparam logic [3:0] ALU_SHL  = 4'h9;
    localparam logic [3:0] ALU_ROR  = 4'hA;
    localparam logic [3:0] ALU_ROL  = 4'hB;
    localparam logic [3:0] ALU_NEG  = 4'hC;
    localparam logic [3:0] ALU_NOT  = 4'hD;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_t;

    // Execute-phase shape; CL_OTHER covers halt and undecoded opcodes.
    typedef enum logic [1:0] {CL_ALU3, CL_MULDIV, CL_UNARY, CL_OTHER} op_class_t;

    typedef struct packed {
        logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout;
        logic MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
        logic IncPC, Read;
        logic Gra, Grb, Grc, Rin, Rout;
    } ctrl_t;

    function automatic op_class_t op_class(logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return CL_ALU3;
            OP_MUL, OP_DIV:                  return CL_MULDIV;
            OP_NEG, OP_NOT:                  return CL_UNARY;
            default:                         return CL_OTHER;
        endcase
    endfunction

    function automatic logic [3:0] alu_sel(logic [4:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHRA: return ALU_SHRA;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> DataPath signal bundle. master = control unit, slave = datapath.
interface control_unit_if;
    import minisrc_pkg::*;

    logic                Stop;
    logic [31:0]         IR;
    logic                PCout, Zlowout, Zhighout, MDRout, LOout, HIout;
    logic                MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
    logic                IncPC, Read;
    logic                Gra, Grb, Grc, Rin, Rout;
    logic [CU_ALU_W-1:0] alu_op;
    logic                Run, illegal;

    modport master (
        input  Stop, IR,
        output PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output alu_op, Run, illegal
    );

    modport slave (
        output Stop, IR,
        input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  alu_op, Run, illegal
    );

endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for MiniSRC: fetch T0-T2, execute T3-T6, HALT.
// Outputs decode only the state register and the opcode latched at the end of T2.
module control_unit
    import minisrc_pkg::*;
#(
    parameter int OPC_W = CU_OPC_W,
    parameter int ALU_W = CU_ALU_W
) (
    input  logic           Clock,
    input  logic           Reset,
    control_unit_if.master cu
);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             illegal_q, illegal_d;
    op_class_t        cls;
    ctrl_t            ctrl;
    logic [ALU_W-1:0] alu_c;

    assign cls = op_class(opc_q);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_RST;
            opc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = cu.Stop ? ST_HALT : ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2: begin
                state_d = ST_T3;
                opc_d   = cu.IR[31 -: OPC_W];
            end
            ST_T3: begin
                if (cls == CL_OTHER) begin
                    state_d   = ST_HALT;
                    illegal_d = illegal_q | (opc_q != OP_HALT);
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T4:   state_d = (cls == CL_UNARY)  ? ST_T0 : ST_T5;
            ST_T5:   state_d = (cls == CL_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        ctrl  = '0;
        alu_c = '0;
        case (state_q)
            ST_T0: begin
                ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; ctrl.Zin = 1'b1;
            end
            ST_T1: begin
                ctrl.Zlowout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1; ctrl.MDRin = 1'b1;
            end
            ST_T2: begin
                ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_ALU3:   begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                    CL_MULDIV: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                    CL_UNARY: begin
                        ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1;
                        alu_c    = alu_sel(opc_q);
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU3: begin
                        ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1;
                        alu_c    = alu_sel(opc_q);
                    end
                    CL_MULDIV: begin
                        ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1;
                        alu_c    = alu_sel(opc_q);
                    end
                    CL_UNARY: begin ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                if (cls == CL_MULDIV) begin
                    ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1;
                end else begin
                    ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
                end
            end
            ST_T6: begin
                ctrl.Zhighout = 1'b1; ctrl.HIin = 1'b1;
            end
            default: ;
        endcase
    end

    assign cu.PCout    = ctrl.PCout;
    assign cu.Zlowout  = ctrl.Zlowout;
    assign cu.Zhighout = ctrl.Zhighout;
    assign cu.MDRout   = ctrl.MDRout;
    assign cu.LOout    = ctrl.LOout;
    assign cu.HIout    = ctrl.HIout;
    assign cu.MARin    = ctrl.MARin;
    assign cu.Zin      = ctrl.Zin;
    assign cu.PCin     = ctrl.PCin;
    assign cu.MDRin    = ctrl.MDRin;
    assign cu.IRin     = ctrl.IRin;
    assign cu.Yin      = ctrl.Yin;
    assign cu.LOin     = ctrl.LOin;
    assign cu.HIin     = ctrl.HIin;
    assign cu.IncPC    = ctrl.IncPC;
    assign cu.Read     = ctrl.Read;
    assign cu.Gra      = ctrl.Gra;
    assign cu.Grb      = ctrl.Grb;
    assign cu.Grc      = ctrl.Grc;
    assign cu.Rin      = ctrl.Rin;
    assign cu.Rout     = ctrl.Rout;
    assign cu.alu_op   = alu_c;
    assign cu.Run      = (state_q != ST_RST) && (state_q != ST_HALT);
    assign cu.illegal  = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch/execute strobe sequences, latency,
// reset, Stop handling, halt and illegal opcodes.
module tb_control_unit;

    logic Clock;
    logic Reset;
    int   tests = 0;
    int   fails = 0;

    control_unit_if cu_if();
    control_unit dut (.Clock(Clock), .Reset(Reset), .cu(cu_if));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Strobe vector layout used for every expectation in this bench.
    localparam logic [20:0] PCO  = 21'h100000, ZLO = 21'h080000, ZHI = 21'h040000;
    localparam logic [20:0] MDRO = 21'h020000, LOO = 21'h010000, HIO = 21'h008000;
    localparam logic [20:0] MARI = 21'h004000, ZI  = 21'h002000, PCI = 21'h001000;
    localparam logic [20:0] MDRI = 21'h000800, IRI = 21'h000400, YI  = 21'h000200;
    localparam logic [20:0] LOI  = 21'h000100, HII = 21'h000080, INC = 21'h000040;
    localparam logic [20:0] RD   = 21'h000020, GA  = 21'h000010, GB  = 21'h000008;
    localparam logic [20:0] GC   = 21'h000004, RI  = 21'h000002, RO  = 21'h000001;
    localparam logic [20:0] BUS  = PCO | ZLO | ZHI | MDRO | LOO | HIO | RO;
    localparam logic [20:0] F0   = PCO | MARI | INC | ZI;
    localparam logic [20:0] F1   = ZLO | PCI | RD | MDRI;
    localparam logic [20:0] F2   = MDRO | IRI;
    localparam logic [31:0] IR_JUNK = 32'hF800_0000;

    logic [20:0] strb;
    logic [25:0] obs;
    assign strb = {cu_if.PCout, cu_if.Zlowout, cu_if.Zhighout, cu_if.MDRout, cu_if.LOout,
                   cu_if.HIout, cu_if.MARin, cu_if.Zin, cu_if.PCin, cu_if.MDRin, cu_if.IRin,
                   cu_if.Yin, cu_if.LOin, cu_if.HIin, cu_if.IncPC, cu_if.Read, cu_if.Gra,
                   cu_if.Grb, cu_if.Grc, cu_if.Rin, cu_if.Rout};
    assign obs = {strb, cu_if.alu_op, cu_if.Run};

    // At most one bus driver at any time (exactly one is checked per state below).
    always @(negedge Clock) begin
        tests++;
        if ($countones(strb & BUS) > 1) begin
            fails++;
            $display("FAIL bus_onehot t=%0t sources=%b", $time, strb & BUS);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cu_if.Stop = 1'b0;
        cu_if.IR = IR_JUNK;
        step();
        step();
        tests++;
        if ({obs, cu_if.illegal} !== 27'd0) begin
            fails++;
            $display("FAIL reset_state got=%h exp=0", {obs, cu_if.illegal});
        end
        Reset = 1'b0;
        step();
        tests++;
        if (obs !== {F0, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL first_t0 got=%h exp=%h", obs, {F0, 4'h0, 1'b1});
        end
    endtask

    // Entered and left in T0; IR only holds the instruction during T2.
    task automatic test_instr(input logic [31:0] ir, input int cls, input logic [3:0] alu);
        logic [25:0] exp [7];
        int n;
        exp[0] = {F0, 4'h0, 1'b1};
        exp[1] = {F1, 4'h0, 1'b1};
        exp[2] = {F2, 4'h0, 1'b1};
        if (cls == 0) begin
            exp[3] = {GB | RO | YI, 4'h0, 1'b1};
            exp[4] = {GC | RO | ZI, alu, 1'b1};
            exp[5] = {ZLO | GA | RI, 4'h0, 1'b1};
            n = 6;
        end else if (cls == 1) begin
            exp[3] = {GA | RO | YI, 4'h0, 1'b1};
            exp[4] = {GB | RO | ZI, alu, 1'b1};
            exp[5] = {ZLO | LOI, 4'h0, 1'b1};
            exp[6] = {ZHI | HII, 4'h0, 1'b1};
            n = 7;
        end else begin
            exp[3] = {GB | RO | ZI, alu, 1'b1};
            exp[4] = {ZLO | GA | RI, 4'h0, 1'b1};
            n = 5;
        end
        cu_if.IR = IR_JUNK;
        for (int k = 0; k < n; k++) begin
            if (k == 2) cu_if.IR = ir;
            if (k == 3) cu_if.IR = IR_JUNK;
            tests++;
            if (obs !== exp[k]) begin
                fails++;
                $display("FAIL instr_%h_T%0d got=%h exp=%h", ir, k, obs, exp[k]);
            end
            tests++;
            if ($countones(strb & BUS) != 1) begin
                fails++;
                $display("FAIL bus_exact_%h_T%0d got=%b exp=one", ir, k, strb & BUS);
            end
            step();
        end
        tests++;
        if ({obs, cu_if.illegal} !== {F0, 4'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL latency_%h got=%h exp=%h", ir, {obs, cu_if.illegal},
                     {F0, 4'h0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_alu_ops();
        logic [4:0] opc [10] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd16, 5'd18};
        logic [3:0] alu [10] = '{4'h3, 4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'hD};
        int         cls [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
        for (int i = 0; i < 10; i++)
            test_instr({opc[i], 27'h0ABCDEF}, cls[i], alu[i]);
    endtask

    task automatic test_reset_mid();
        cu_if.IR = 32'h1A2B_8000;
        for (int k = 0; k < 4; k++) step();
        tests++;
        if (obs !== {GC | RO | ZI, 4'h2, 1'b1}) begin
            fails++;
            $display("FAIL pre_reset_T4 got=%h exp=%h", obs, {GC | RO | ZI, 4'h2, 1'b1});
        end
        Reset = 1'b1;
        #2;
        tests++;
        if ({obs, cu_if.illegal} !== 27'd0) begin
            fails++;
            $display("FAIL async_reset got=%h exp=0", {obs, cu_if.illegal});
        end
        step();
        Reset = 1'b0;
        step();
        tests++;
        if (obs !== {F0, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL post_reset_t0 got=%h exp=%h", obs, {F0, 4'h0, 1'b1});
        end
    endtask

    task automatic test_stop_t0();
        cu_if.Stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (obs !== 26'd0) begin
                fails++;
                $display("FAIL stop_t0_halt_%0d got=%h exp=0", k, obs);
            end
        end
        cu_if.Stop = 1'b0;
        step();
        tests++;
        if (obs !== 26'd0) begin
            fails++;
            $display("FAIL halt_absorbing got=%h exp=0", obs);
        end
        do_reset();
    endtask

    task automatic test_stop_mid();
        cu_if.IR = 32'h1A2B_8000;
        for (int k = 0; k < 4; k++) step();
        cu_if.Stop = 1'b1;
        step();
        tests++;
        if (obs !== {ZLO | GA | RI, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL stop_mid_T5 got=%h exp=%h", obs, {ZLO | GA | RI, 4'h0, 1'b1});
        end
        step();
        tests++;
        if (obs !== {F0, 4'h0, 1'b1}) begin
            fails++;
            $display("FAIL stop_mid_T0 got=%h exp=%h", obs, {F0, 4'h0, 1'b1});
        end
        step();
        tests++;
        if (obs !== 26'd0) begin
            fails++;
            $display("FAIL stop_mid_halt got=%h exp=0", obs);
        end
        cu_if.Stop = 1'b0;
        do_reset();
    endtask

    task automatic test_illegal(input logic [31:0] ir, input logic exp_ill);
        cu_if.IR = ir;
        for (int k = 0; k < 3; k++) step();
        tests++;
        if ({obs, cu_if.illegal} !== {21'd0, 4'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL t3_%h got=%h exp=%h", ir, {obs, cu_if.illegal},
                     {21'd0, 4'h0, 1'b1, 1'b0});
        end
        for (int k = 0; k < 11; k++) begin
            step();
            tests++;
            if ({obs, cu_if.illegal} !== {26'd0, exp_ill}) begin
                fails++;
                $display("FAIL halt_%h_%0d got=%h exp=%h", ir, k, {obs, cu_if.illegal},
                         {26'd0, exp_ill});
            end
        end
        do_reset();
        tests++;
        if (cu_if.illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_cleared got=%b exp=0", cu_if.illegal);
        end
    endtask

    initial begin
        test_reset();
        test_instr(32'h1A2B_8000, 0, 4'h2);
        test_instr(32'h7930_0000, 1, 4'h4);
        test_instr(32'h8800_0000, 2, 4'hC);
        test_alu_ops();
        test_reset_mid();
        test_stop_t0();
        test_stop_mid();
        test_illegal(32'hF800_0000, 1'b1);
        test_illegal(32'hE000_0000, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
